// File: rtl/alu_instr_queue.sv
// Instruction FIFO feeding the ALU with a first-word fall-through valid/ready issue port.
// Optional zero-latency bypass on an empty queue is enabled by defining ALU_QUEUE_BYPASS_EN.
module alu_instr_queue #(
    parameter int DEPTH      = 4,
    parameter int OPCODE_W   = 3,
    parameter int OPERAND_W  = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            flush,
    input  logic                            load_en,
    input  logic [OPCODE_W-1:0]             opcode,
    input  logic [OPERAND_W-1:0]            operand_a,
    input  logic [OPERAND_W-1:0]            operand_b,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [OPCODE_W+2*OPERAND_W-1:0] instruction_word,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            full,
    output logic                            empty,
    output logic [DROP_CNT_W-1:0]           drop_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = OPCODE_W + 2 * OPERAND_W;

    logic [WORD_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [WORD_W-1:0]     r_word;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic [WORD_W-1:0]     w_din;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_bypass;
    logic                  w_bypass_take;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [PTR_W-1:0]      w_rd_next;
    logic [CNT_W-1:0]      w_count_next;
    logic [WORD_W-1:0]     w_head_next;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

    assign w_din   = {opcode, operand_a, operand_b};
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef ALU_QUEUE_BYPASS_EN
    assign w_bypass = w_empty & load_en & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed instruction taken by the ALU in the same cycle never enters the queue.
    assign w_bypass_take = w_bypass & issue_ready;
    assign w_pop         = ~w_empty & issue_ready & ~flush;
    assign w_push        = load_en & (~w_full | w_pop) & ~w_bypass_take & ~flush;
    assign w_drop        = load_en & w_full & ~w_pop & ~flush;
    assign w_rd_next     = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // The next head may be the entry being written this very edge.
    assign w_head_next = (w_push && (w_rd_next == r_wr_ptr)) ? w_din : r_mem[w_rd_next];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            // Output word is registered so it holds its last value once the queue drains.
            if (w_count_next != '0) begin
                r_word <= w_head_next;
            end else if (w_bypass_take) begin
                r_word <= w_din;
            end
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    assign issue_valid      = ~w_empty | w_bypass;
    assign instruction_word = w_bypass ? w_din : r_word;
    assign count            = r_count;
    assign full             = w_full;
    assign empty            = w_empty;
    assign drop_count       = r_drop_cnt;

endmodule

// File: tb/tb_alu_instr_queue.sv
// Directed self-checking bench for alu_instr_queue (DEPTH=4, 3-bit opcode, 4-bit operands).
module tb_alu_instr_queue;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        load_en;
    logic [2:0]  opcode;
    logic [3:0]  operand_a;
    logic [3:0]  operand_b;
    logic        issue_valid;
    logic        issue_ready;
    logic [10:0] instruction_word;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;

    alu_instr_queue #(
        .DEPTH(4), .OPCODE_W(3), .OPERAND_W(4), .DROP_CNT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .load_en(load_en),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .instruction_word(instruction_word), .count(count), .full(full),
        .empty(empty), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; load_en = 1'b0; issue_ready = 1'b0;
        opcode = '0; operand_a = '0; operand_b = '0;

        // Reset then idle
        step(); step();
        reset_n = 1'b1;
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_valid", 32'(issue_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_drop", 32'(drop_count), 0);
        check("rst_word", 32'(instruction_word), 0);

        // Single push, stall, then pop
        load_en = 1'b1; opcode = 3'd2; operand_a = 4'd5; operand_b = 4'd3;
        step();
        load_en = 1'b0;
        check("one_valid", 32'(issue_valid), 1);
        check("one_word", 32'(instruction_word), 32'b010_0101_0011);
        check("one_count", 32'(count), 1);
        step();
        check("stall_valid", 32'(issue_valid), 1);
        check("stall_word", 32'(instruction_word), 32'b010_0101_0011);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        check("one_empty", 32'(empty), 1);
        check("one_valid0", 32'(issue_valid), 0);
        check("one_hold", 32'(instruction_word), 32'b010_0101_0011);

        // Fill and overflow
        opcode = 3'd1; operand_b = 4'd0;
        for (int i = 1; i <= 6; i++) begin
            load_en = 1'b1; operand_a = 4'(i);
            step();
        end
        load_en = 1'b0;
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 4);
        check("fill_drop", 32'(drop_count), 2);
        issue_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_a", 32'(instruction_word[7:4]), 32'(k));
            step();
        end
        issue_ready = 1'b0;
        check("drain_empty", 32'(empty), 1);

        // Simultaneous push/pop while full
        for (int i = 1; i <= 4; i++) begin
            load_en = 1'b1; operand_a = 4'(i);
            step();
        end
        check("sim_pre_full", 32'(full), 1);
        check("sim_head", 32'(instruction_word[7:4]), 1);
        operand_a = 4'd9; issue_ready = 1'b1;
        step();
        load_en = 1'b0;
        check("sim_count", 32'(count), 4);
        check("sim_drop", 32'(drop_count), 2);
        begin
            logic [3:0] exp_seq [4];
            exp_seq = '{4'd2, 4'd3, 4'd4, 4'd9};
            for (int k = 0; k < 4; k++) begin
                check("sim_drain", 32'(instruction_word[7:4]), 32'(exp_seq[k]));
                step();
            end
        end
        issue_ready = 1'b0;
        check("sim_empty", 32'(empty), 1);

        // Flush with a push and pop presented in the same cycle
        for (int i = 7; i <= 9; i++) begin
            load_en = 1'b1; operand_a = 4'(i);
            step();
        end
        check("fl_pre", 32'(count), 3);
        flush = 1'b1; issue_ready = 1'b1; operand_a = 4'd12;
        step();
        flush = 1'b0; load_en = 1'b0; issue_ready = 1'b0;
        check("fl_count", 32'(count), 0);
        check("fl_valid", 32'(issue_valid), 0);
        check("fl_drop", 32'(drop_count), 2);
        for (int i = 1; i <= 2; i++) begin
            load_en = 1'b1; operand_a = 4'(i);
            step();
        end
        load_en = 1'b0;
        check("refill_count", 32'(count), 2);
        check("refill_head", 32'(instruction_word[7:4]), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_count", 32'(count), 0);
        check("async_valid", 32'(issue_valid), 0);
        check("async_drop", 32'(drop_count), 0);
        check("async_word", 32'(instruction_word), 0);
        reset_n = 1'b1;
        step();

        // Wrap-around with back-to-back push/pop
        load_en = 1'b1; opcode = 3'd0; operand_a = 4'd0; operand_b = 4'hF;
        step();
        issue_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            logic [3:0] p;
            p = 4'(i - 1);
            opcode = 3'(i); operand_a = 4'(i); operand_b = ~4'(i);
            check("wrap_word", 32'(instruction_word), 32'({p[2:0], p, ~p}));
            check("wrap_count", 32'(count), 1);
            step();
        end
        load_en = 1'b0;
        check("wrap_last", 32'(instruction_word), 32'({3'd2, 4'd10, 4'd5}));
        step();
        issue_ready = 1'b0;
        check("wrap_empty", 32'(empty), 1);

`ifdef ALU_QUEUE_BYPASS_EN
        // Zero-latency bypass on an empty queue
        load_en = 1'b1; issue_ready = 1'b1;
        opcode = 3'd5; operand_a = 4'd6; operand_b = 4'd7;
        #1;
        check("byp_valid", 32'(issue_valid), 1);
        check("byp_word", 32'(instruction_word), 32'({3'd5, 4'd6, 4'd7}));
        step();
        load_en = 1'b0; issue_ready = 1'b0;
        check("byp_count", 32'(count), 0);
        check("byp_empty", 32'(empty), 1);
`endif

        // Drop counter saturation, contents untouched
        opcode = 3'd3; operand_b = 4'd1;
        for (int i = 0; i < 264; i++) begin
            load_en = 1'b1; operand_a = 4'(i);
            step();
        end
        load_en = 1'b0;
        check("sat_count", 32'(count), 4);
        check("sat_drop", 32'(drop_count), 255);
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("sat_drain", 32'(instruction_word[7:4]), 32'(k));
            step();
        end
        issue_ready = 1'b0;
        check("sat_empty", 32'(empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
